// File: rtl/des_decrypt_iter.sv
// Iterative DES block cipher: one Feistel round per clock, decryption by default.
// Optional macro DES_ENC_MODE_EN adds an 'enc' input that selects encryption per block.
// des_fblock is the shared DES round function (expansion, S-boxes, P permutation).

module des_fblock (
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f_c
);

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box holds 64 nibbles, row-major (row = b1b6, col = b2..b5), first entry in the MSBs.
  localparam logic [255:0] S_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [47:0] x;
  logic [31:0] s_out;
  logic [5:0]  six;
  logic [5:0]  idx;

  // Expand, mix in the subkey, substitute through the eight S-boxes, then permute.
  always_comb begin
    x     = '0;
    s_out = '0;
    six   = '0;
    idx   = '0;
    f_c   = '0;
    for (int i = 0; i < 48; i++) x = {x[46:0], r[5'(32 - E_T[i])]};
    x = x ^ k;
    for (int s = 0; s < 8; s++) begin
      six   = x[6'(47 - 6 * s) -: 6];
      idx   = {six[5], six[0], six[4:1]};
      s_out = {s_out[27:0], S_T[s][8'(255 - 4 * 32'(idx)) -: 4]};
    end
    for (int i = 0; i < 32; i++) f_c = {f_c[30:0], s_out[5'(32 - P_T[i])]};
  end

endmodule

module des_decrypt_iter (
`ifdef DES_ENC_MODE_EN
  input  logic        enc,
`endif
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] din,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dout,
  output logic        busy
);

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int unsigned FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [3:0] LAST_ROUND = 4'd15;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IP_T[i])]};
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - FP_T[i])]};
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y = '0;
    for (int i = 0; i < 56; i++) y = {y[54:0], x[6'(64 - PC1_T[i])]};
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y = '0;
    for (int i = 0; i < 48; i++) y = {y[46:0], x[6'(56 - PC2_T[i])]};
    return y;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] dout_q, dout_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        enc_q, enc_d;

  logic [1:0]  shamt;
  logic        rot_left;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [31:0] r_new;
  logic [63:0] ip_w;
  logic [55:0] pc1_w;

  // Key-schedule step for the current round: shift amount, direction and rotated halves.
  always_comb begin
    shamt    = 2'd2;
    rot_left = 1'b0;
    c_rot    = c_q;
    d_rot    = d_q;
    if (enc_q) begin
      rot_left = 1'b1;
      if (cnt_q == 4'd0 || cnt_q == 4'd1 || cnt_q == 4'd8 || cnt_q == 4'd15) shamt = 2'd1;
    end else begin
      if (cnt_q == 4'd0) shamt = 2'd0;
      else if (cnt_q == 4'd1 || cnt_q == 4'd8 || cnt_q == 4'd15) shamt = 2'd1;
    end
    case ({rot_left, shamt})
      3'b001:  begin c_rot = {c_q[0], c_q[27:1]};     d_rot = {d_q[0], d_q[27:1]};     end
      3'b010:  begin c_rot = {c_q[1:0], c_q[27:2]};   d_rot = {d_q[1:0], d_q[27:2]};   end
      3'b101:  begin c_rot = {c_q[26:0], c_q[27]};    d_rot = {d_q[26:0], d_q[27]};    end
      3'b110:  begin c_rot = {c_q[25:0], c_q[27:26]}; d_rot = {d_q[25:0], d_q[27:26]}; end
      default: begin c_rot = c_q;                     d_rot = d_q;                     end
    endcase
    subkey = perm_pc2({c_rot, d_rot});
  end

  des_fblock u_fblock (
    .r   (r_q),
    .k   (subkey),
    .f_c (f_out)
  );

  // Next-state and datapath: load on transfer, one round per cycle, hold result until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    enc_d       = enc_q;
    r_new       = l_q ^ f_out;
    ip_w        = perm_ip(din);
    pc1_w       = perm_pc1(key);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = ip_w[63:32];
          r_d     = ip_w[31:0];
          c_d     = pc1_w[55:28];
          d_d     = pc1_w[27:0];
          cnt_d   = '0;
`ifdef DES_ENC_MODE_EN
          enc_d   = enc;
`else
          enc_d   = 1'b0;
`endif
          state_d = ROUND;
        end
      end
      ROUND: begin
        l_d = r_q;
        r_d = r_new;
        c_d = c_rot;
        d_d = d_rot;
        if (cnt_q == LAST_ROUND) begin
          dout_d      = perm_fp({r_new, r_q});
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      enc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      enc_q       <= enc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign busy      = busy_q;

endmodule
